// File: rtl/mau_pkg.sv
// Shared encodings, widths and the state type for the load/store sequencer.
// Also holds the alignment/legality rule used when a request is accepted.
package mau_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Reserved size, odd halfword address or unaligned word never touches memory.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Big-endian lane logic: extracts/extends a loaded byte or halfword and
// merges a right-justified store value into a full memory word.
module mau_lane
  import mau_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_W
) (
  input  logic [WORD_WIDTH-1:0] rd_word,
  input  logic [WORD_WIDTH-1:0] base_word,
  input  logic [WORD_WIDTH-1:0] st_data,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic [WORD_WIDTH-1:0] load_data,
  output logic [WORD_WIDTH-1:0] merged_word
);

  logic [4:0]            shamt;
  logic [WORD_WIDTH-1:0] shifted;
  logic [WORD_WIDTH-1:0] lane_mask;
  logic [WORD_WIDTH-1:0] lane_data;

  // Byte offset k sits k bytes below the MSB, so shifting left by 8k brings it to the top.
  always_comb begin
    shamt   = {offset, 3'b000};
    shifted = rd_word << shamt;
    case (size)
      SZ_BYTE: load_data = {{(WORD_WIDTH-8){sign_ext & shifted[WORD_WIDTH-1]}},
                            shifted[WORD_WIDTH-1 -: 8]};
      SZ_HALF: load_data = {{(WORD_WIDTH-16){sign_ext & shifted[WORD_WIDTH-1]}},
                            shifted[WORD_WIDTH-1 -: 16]};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: begin
        lane_mask = {8'hFF, {(WORD_WIDTH-8){1'b0}}} >> shamt;
        lane_data = {st_data[7:0], {(WORD_WIDTH-8){1'b0}}} >> shamt;
      end
      SZ_HALF: begin
        lane_mask = {16'hFFFF, {(WORD_WIDTH-16){1'b0}}} >> shamt;
        lane_data = {st_data[15:0], {(WORD_WIDTH-16){1'b0}}} >> shamt;
      end
      default: begin
        lane_mask = {WORD_WIDTH{1'b1}};
        lane_data = st_data;
      end
    endcase
    merged_word = (base_word & ~lane_mask) | (lane_data & lane_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one access per request, sub-word stores done as
// read-modify-write against a word-wide big-endian data memory.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_ext_q, sign_ext_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  err_q, err_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;

  logic [WORD_WIDTH-1:0] load_data;
  logic [WORD_WIDTH-1:0] merged_word;

  // Extraction reads the live memory word so rdata can update on the RD-ending edge.
  mau_lane #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_lane (
    .rd_word     (mem_rdata),
    .base_word   (word_q),
    .st_data     (wdata_q),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .sign_ext    (sign_ext_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      sign_ext_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word_q     <= word_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sign_ext_d = sign_ext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word_d     = word_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d       = we;
          size_d     = size;
          sign_ext_d = sign_ext;
          addr_d     = addr;
          wdata_d    = wdata;
          err_d      = is_illegal(size, addr[1:0]);
          if (is_illegal(size, addr[1:0])) begin
            state_d = ST_DONE;
          end else if (we && (size == SZ_WORD)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        word_d = mem_rdata;
        if (we_q) begin
          state_d = ST_WR;
        end else begin
          rdata_d = load_data;
          state_d = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    err       = (state_q == ST_DONE) && err_q;
    rdata     = rdata_q;
    mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    mem_rd    = (state_q == ST_RD);
    mem_wr    = (state_q == ST_WR);
    mem_wdata = (state_q == ST_WR) ? merged_word : '0;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequential load/store sequencer between the processor's memory stage and the word-wide, byte-addressed, big-endian data memory. It accepts one byte, halfword or word access per request and checks alignment. Loads are extracted and sign- or zero-extended; sub-word stores are done as a read-modify-write, because the memory always writes four bytes. A single `done` pulse reports completion, or an error for illegal accesses.

## Interface
- `WORD_WIDTH`, 32, processor/memory word width
- `ADDR_WIDTH`, 32, byte address width
- `clk` in 1: rising-edge clock shared with data memory
- `rst` in 1: asynchronous, active-high reset
- `req` in 1: access request; sampled only when `busy`=0
- `we` in 1: 1 = store, 0 = load
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved
- `sign_ext` in 1: loads only; 1 = sign-extend, 0 = zero-extend
- `addr` in ADDR_WIDTH: byte address
- `wdata` in WORD_WIDTH: store data, right-justified (byte in [7:0], half in [15:0])
- `busy` out 1: access in progress; `req` ignored
- `done` out 1: one-cycle completion pulse
- `err` out 1: valid with `done`; misaligned or reserved size, no memory access made
- `rdata` out WORD_WIDTH: extended load result; updated on load completion, held otherwise
- `mem_addr` out ADDR_WIDTH: word-aligned address (`addr` with [1:0]=00)
- `mem_rd` out 1: memory read enable
- `mem_wr` out 1: memory write enable; the memory writes at the rising edge that ends the cycle
- `mem_wdata` out WORD_WIDTH: full word to write
- `mem_rdata` in WORD_WIDTH: combinational read data from memory

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE → (`req`) latch `we`, `size`, `sign_ext`, `addr`, `wdata`. Next state:
  - illegal access → DONE with error flag set. Illegal = `size`=11, or half with addr[0]=1, or word with addr[1:0]≠00.
  - load or sub-word store → RD.
  - word store → WR.
- RD: `mem_rd`=1; capture `mem_rdata` into the word register at the cycle-end edge. Next state is DONE for a load, WR for a store.
- WR: `mem_wr`=1 and `mem_wdata` = merged word → DONE.
  - word store: merged word = stored wdata.
  - sub-word store: merged word = captured word with the target lane replaced.
- DONE: `done`=1; `err` = error flag; on a legal load, `rdata` takes the extracted value at the edge entering DONE → IDLE.
- Lane mapping is big-endian:
  - byte offset k occupies bits [31-8k : 24-8k].
  - half at offset 0 occupies [31:16]; half at offset 2 occupies [15:0].
- Extension: `sign_ext`=1 replicates the lane MSB; `sign_ext`=0 fills with zero. Word loads pass through unchanged.
- `mem_rd`, `mem_wr` and `mem_wdata` are 0 outside RD/WR. `mem_addr` is held from the latched address while busy.
- `busy`=1 in RD, WR and DONE.

## Timing
- Reset: state IDLE; `busy`, `done`, `err`, `rdata`, `mem_addr`, `mem_rd`, `mem_wr`, `mem_wdata` all 0.
- Accept edge = rising edge with `req`=1 in IDLE. `done` is high during:
  - cycle 1 after accept for an error;
  - cycle 2 for a load or word store;
  - cycle 3 for a sub-word store.
- Back-to-back requests: a `req` held through DONE is accepted at the first edge in IDLE. Minimum spacing is one idle cycle.
- `req` while `busy`: ignored and not queued.
- Reset asserted in RD or WR: outputs clear immediately and no memory write occurs. A write completes only if `rst` stays low through the WR-ending edge.
- Error path never asserts `mem_rd` or `mem_wr`, and leaves `rdata` unchanged.

## Structure
- Package `mau_pkg`: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, width constants.
- Sub-module `mau_lane`: combinational. Lane extraction with sign/zero extension, and store-lane merge, from offset and size. Instantiated once.

## Test plan
- Memory word at 0x10 = 0x8899AABB:
  - `lb` 0x11 signed → `rdata`=0xFFFFFF99, `done` at cycle 2;
  - `lbu` 0x11 → 0x00000099.
- `lh` 0x12 signed → 0xFFFFAABB; `lhu` 0x10 → 0x00008899.
- `sb` 0x13, `wdata`=0x5A → one RD, one WR, `mem_wdata`=0x8899AA5A, `done` at cycle 3; a later `lw` 0x10 returns 0x8899AA5A.
- `sw` 0x20, 0xDEADBEEF → no RD, `mem_wr` 1 cycle, `done` at cycle 2; `lw` 0x20 returns 0xDEADBEEF.
- `lh` 0x11, `sw` 0x22, and `size`=11 → each: `done`+`err` at cycle 1, no `mem_rd`/`mem_wr`, `rdata` held.
- `sh` 0x10 with `rst` pulsed during RD → all outputs 0 immediately, memory unchanged; a new request is accepted after reset release.
